// File: rtl/alu_md_control.sv
// RV32 EX-stage ALU control decode plus an iterative M-extension multiply/divide
// engine (shift-add multiply, restoring divide) that stalls EX while it runs.
module alu_md_control #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      ALUOp_i,
  input  logic [6:0]      funct7_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [2:0]      alu_ctrl_o,
  output logic            md_sel_o,
  output logic            stall_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_NOP = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  typedef enum logic [1:0] {IDLE, PREP, CALC, FIX} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [XLEN-1:0]   md_result_q, md_result_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d, rneg_q, rneg_d;
  logic              md_done_q, md_done_d;

  logic              is_m, accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     add_sum, rem_sh;
  logic [XLEN-1:0]   rem_sub;
  logic [2*XLEN-1:0] acc_step, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_result;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin : decode
    alu_ctrl_o = ALU_NOP;
    case (ALUOp_i)
      3'b000, 3'b010: alu_ctrl_o = ALU_ADD;
      3'b001: begin
        if (funct3_i == 3'b000) alu_ctrl_o = ALU_ADD;
        else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) alu_ctrl_o = ALU_SRA;
      end
      3'b011: begin
        if (funct7_i == 7'b0000000) begin
          case (funct3_i)
            3'b000:  alu_ctrl_o = ALU_ADD;
            3'b111:  alu_ctrl_o = ALU_AND;
            3'b100:  alu_ctrl_o = ALU_XOR;
            3'b001:  alu_ctrl_o = ALU_SLL;
            default: alu_ctrl_o = ALU_NOP;
          endcase
        end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
          alu_ctrl_o = ALU_SUB;
        end
      end
      3'b110:  alu_ctrl_o = ALU_SUB;
      default: alu_ctrl_o = ALU_NOP;
    endcase
  end

  assign is_m     = (ALUOp_i == 3'b011) && (funct7_i == 7'b0000001);
  assign md_sel_o = is_m;
  assign accept   = (state_q == IDLE) && valid_i && is_m && !flush_i;

  // Signed sources: MULH both, MULHSU rs1 only, DIV/REM both.
  assign a_signed = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b100) || (op_q == 3'b110);
  assign b_signed = (op_q == 3'b001) || (op_q == 3'b100) || (op_q == 3'b110);
  assign a_neg    = a_signed && rs1_q[XLEN-1];
  assign b_neg    = b_signed && rs2_q[XLEN-1];
  assign a_mag    = a_neg ? -rs1_q : rs1_q;
  assign b_mag    = b_neg ? -rs2_q : rs2_q;

  // One iteration; acc holds {partial product, multiplier} or {remainder, quotient}.
  always_comb begin : step
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opd_q};
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_sub = rem_sh[XLEN-1:0] - opd_q;
    if (op_q[2]) begin
      if (rem_sh >= {1'b0, opd_q}) acc_step = {rem_sub, acc_q[XLEN-2:0], 1'b1};
      else                         acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_step = {add_sum, acc_q[XLEN-1:1]};
    end else begin
      acc_step = {1'b0, acc_q[2*XLEN-1:1]};
    end

    prod_fix = neg_q  ? -acc_step : acc_step;
    quo_fix  = neg_q  ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
    rem_fix  = rneg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_result = quo_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_comb begin : next_state
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    opd_d       = opd_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    rneg_d      = rneg_q;
    md_done_d   = 1'b0;
    md_result_d = md_result_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = PREP;
        op_d    = funct3_i;
        rs1_d   = rs1_i;
        rs2_d   = rs2_i;
      end
      PREP: begin
        opd_d  = op_q[2] ? b_mag : a_mag;
        acc_d  = {{XLEN{1'b0}}, (op_q[2] ? a_mag : b_mag)};
        neg_d  = a_neg ^ b_neg;
        rneg_d = a_neg;
        cnt_d  = CNT_W'(XLEN);
        if (op_q[2] && rs2_q == '0) begin
          state_d     = FIX;
          md_done_d   = 1'b1;
          md_result_d = op_q[1] ? rs1_q : '1;
        end else begin
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = FIX;
          md_done_d   = 1'b1;
          md_result_d = fix_result;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d     = IDLE;
      md_done_d   = 1'b0;
      md_result_d = md_result_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      opd_q       <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      md_done_q   <= 1'b0;
      md_result_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      opd_q       <= opd_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      rneg_q      <= rneg_d;
      md_done_q   <= md_done_d;
      md_result_q <= md_result_d;
    end
  end

  assign stall_o     = !rst_i && !flush_i && (accept || state_q == PREP || state_q == CALC);
  assign md_done_o   = md_done_q && !flush_i && !rst_i;
  assign md_result_o = md_result_q;
endmodule

// File: tb/tb_alu_md_control.sv
// Directed + scoreboard bench for alu_md_control: decode, M-op results, latency,
// stall window, flush and synchronous reset.
module tb_alu_md_control;
  logic        clk_i = 1'b0;
  logic        rst_i, valid_i, flush_i;
  logic [2:0]  ALUOp_i, funct3_i;
  logic [6:0]  funct7_i;
  logic [31:0] rs1_i, rs2_i;
  logic [2:0]  alu_ctrl_o;
  logic        md_sel_o, stall_o, md_done_o;
  logic [31:0] md_result_o;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q[$];

  alu_md_control #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .funct7_i(funct7_i), .funct3_i(funct3_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .alu_ctrl_o(alu_ctrl_o), .md_sel_o(md_sel_o),
    .stall_o(stall_o), .md_done_o(md_done_o), .md_result_o(md_result_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of the RISC-V M extension, written independently of the engine.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            else return $signed(a) / $signed(b);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) return a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            else return $signed(a) % $signed(b);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic dec(input string tag, input logic [2:0] op, input logic [6:0] f7,
                     input logic [2:0] f3, input logic [2:0] exp_ctrl, input logic exp_sel);
    valid_i = 1'b0; ALUOp_i = op; funct7_i = f7; funct3_i = f3;
    #1;
    check({tag, "_ctrl"}, 32'(alu_ctrl_o), 32'(exp_ctrl));
    check({tag, "_sel"}, 32'(md_sel_o), 32'(exp_sel));
  endtask

  // Called just after a rising edge; this cycle is the accept cycle.
  task automatic start_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    valid_i = 1'b1; ALUOp_i = 3'b011; funct7_i = 7'b0000001;
    funct3_i = f3; rs1_i = a; rs2_i = b;
    exp_q.push_back(exp);
    @(negedge clk_i);
    check("accept_stall", 32'(stall_o), 32'd1);
  endtask

  // Scrambles inputs while busy, then checks latency, stall window and result.
  task automatic wait_done(input string tag, input int exp_lat);
    int   stalls = 0;
    logic seen = 1'b0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk_i); #1;
      valid_i = 1'b1; funct3_i = 3'($urandom); rs1_i = $urandom; rs2_i = $urandom;
      @(negedge clk_i);
      if (md_done_o) begin
        seen = 1'b1;
        check({tag, "_latency"}, 32'(k), 32'(exp_lat));
        check({tag, "_stalls"}, 32'(stalls), 32'(exp_lat - 1));
        check({tag, "_fix_stall"}, 32'(stall_o), 32'd0);
        if (exp_q.size() == 0) check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
        else check({tag, "_result"}, md_result_o, exp_q.pop_front());
      end else if (stall_o) begin
        stalls++;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    int          done_cnt;

    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    ALUOp_i = 3'b000; funct7_i = '0; funct3_i = '0; rs1_i = '0; rs2_i = '0;
    @(negedge clk_i);
    check("rst_done", 32'(md_done_o), 32'd0);
    check("rst_result", md_result_o, 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_i = 1'b0;

    dec("sub",   3'b011, 7'b0100000, 3'b000, 3'b001, 1'b0);
    check("sub_stall", 32'(stall_o), 32'd0);
    dec("srai",  3'b001, 7'b0100000, 3'b101, 3'b111, 1'b0);
    dec("unlst", 3'b011, 7'b0000000, 3'b010, 3'b011, 1'b0);
    dec("lw",    3'b000, 7'b1111111, 3'b010, 3'b000, 1'b0);
    dec("sw",    3'b010, 7'b0000000, 3'b010, 3'b000, 1'b0);
    dec("addi",  3'b001, 7'b0101010, 3'b000, 3'b000, 1'b0);
    dec("and",   3'b011, 7'b0000000, 3'b111, 3'b100, 1'b0);
    dec("xor",   3'b011, 7'b0000000, 3'b100, 3'b101, 1'b0);
    dec("sll",   3'b011, 7'b0000000, 3'b001, 3'b110, 1'b0);
    dec("beq",   3'b110, 7'b0000000, 3'b000, 3'b001, 1'b0);
    dec("m_op",  3'b011, 7'b0000001, 3'b000, 3'b011, 1'b1);
    check("m_noval_stall", 32'(stall_o), 32'd0);

    @(posedge clk_i); #1;
    start_m(3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE); wait_done("mul", 34);
    start_m(3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001); wait_done("mulhu", 34);
    start_m(3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF); wait_done("mulh", 34);
    start_m(3'd4, -32'sd7, 32'd2, 32'hFFFF_FFFD);        wait_done("div", 34);
    start_m(3'd6, -32'sd7, 32'd2, 32'hFFFF_FFFF);        wait_done("rem", 34);
    start_m(3'd5, 32'd100, 32'd7, 32'd14);               wait_done("divu", 34);
    start_m(3'd7, 32'd100, 32'd7, 32'd2);                wait_done("remu", 34);
    start_m(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);          wait_done("div0", 2);
    start_m(3'd6, 32'd5, 32'd0, 32'd5);                  wait_done("rem0", 2);
    start_m(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); wait_done("divovf", 34);
    start_m(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);  wait_done("removf", 34);

    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 4 == 3) ? 32'd0 : $urandom;
      start_m(f3, a, b, model(f3, a, b));
      wait_done($sformatf("rnd%0d_f%0d", i, f3), (f3[2] && b == 0) ? 2 : 34);
    end

    // Flush in the middle of CALC.
    valid_i = 1'b1; ALUOp_i = 3'b011; funct7_i = 7'b0000001;
    funct3_i = 3'd0; rs1_i = 32'd9; rs2_i = 32'd9;
    @(negedge clk_i);
    check("fl_accept_stall", 32'(stall_o), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    #1;
    check("fl_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    done_cnt = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (md_done_o) done_cnt++;
    end
    check("fl_no_done", 32'(done_cnt), 32'd0);
    check("fl_idle_stall", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    start_m(3'd0, 32'd3, 32'd4, 32'd12); wait_done("fl_mul", 34);

    // Synchronous reset in the middle of an operation, with a new M op held on valid_i.
    valid_i = 1'b1; ALUOp_i = 3'b011; funct7_i = 7'b0000001;
    funct3_i = 3'd0; rs1_i = 32'd6; rs2_i = 32'd7;
    repeat (5) @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check("mr_stall_in_rst", 32'(stall_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("mr_done", 32'(md_done_o), 32'd0);
    check("mr_result", md_result_o, 32'd0);
    check("mr_reaccept_stall", 32'(stall_o), 32'd1);
    exp_q.push_back(32'd42);
    wait_done("mr_mul", 34);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
